// File: rtl/tile_stats_accum.sv
// Per-tile mean/min/max over a raster-order pixel stream. One accumulator entry
// per tile column is reused for every tile row; a record is emitted on each tile's closing pixel.

module tile_stats_entry #(
    parameter int PIX_WIDTH = 8,
    parameter int SUM_W     = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iWe,
    input  logic [SUM_W-1:0]     iSum,
    input  logic [PIX_WIDTH-1:0] iMin,
    input  logic [PIX_WIDTH-1:0] iMax,
    output logic [SUM_W-1:0]     oSum,
    output logic [PIX_WIDTH-1:0] oMin,
    output logic [PIX_WIDTH-1:0] oMax
);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oSum <= '0;
            oMin <= '0;
            oMax <= '0;
        end else if (iWe) begin
            oSum <= iSum;
            oMin <= iMin;
            oMax <= iMax;
        end
    end

endmodule

module tile_stats_accum #(
    parameter int PIX_WIDTH   = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int TILE_WIDTH  = 16,
    parameter int TILE_HEIGHT = 16,
    localparam int TX_W = $clog2(IMG_WIDTH / TILE_WIDTH),
    localparam int TY_W = $clog2(IMG_HEIGHT / TILE_HEIGHT)
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iValid,
    input  logic                 iSof,
    input  logic [PIX_WIDTH-1:0] iData,
    output logic                 oValid,
    output logic [TX_W-1:0]      oTileX,
    output logic [TY_W-1:0]      oTileY,
    output logic [PIX_WIDTH-1:0] oMean,
    output logic [PIX_WIDTH-1:0] oMin,
    output logic [PIX_WIDTH-1:0] oMax,
    output logic                 oFrameDone
);

    localparam int TILES_X = IMG_WIDTH / TILE_WIDTH;
    localparam int TILES_Y = IMG_HEIGHT / TILE_HEIGHT;
    localparam int XW      = $clog2(IMG_WIDTH);
    localparam int YW      = $clog2(IMG_HEIGHT);
    localparam int LXW     = $clog2(TILE_WIDTH);
    localparam int LYW     = $clog2(TILE_HEIGHT);
    localparam int AREA_W  = $clog2(TILE_WIDTH * TILE_HEIGHT);
    localparam int SUM_W   = PIX_WIDTH + AREA_W;
    localparam int STAGES  = 1;

    logic [XW-1:0]   xCnt, effX;
    logic [YW-1:0]   yCnt, effY;
    logic            lastX, lastY;
    logic [TX_W-1:0] col;
    logic [TY_W-1:0] row;
    logic            tileFirst, tileLast;

    logic [TILES_X-1:0]                entWe;
    logic [TILES_X-1:0][SUM_W-1:0]     entSum;
    logic [TILES_X-1:0][PIX_WIDTH-1:0] entMin, entMax;

    logic [SUM_W-1:0]     curSum, nxtSum;
    logic [PIX_WIDTH-1:0] curMin, curMax, nxtMin, nxtMax;
    logic [STAGES:0]      vldPipe;

    // A start-of-frame pixel overrides the running position before anything else uses it.
    assign effX  = (iValid && iSof) ? '0 : xCnt;
    assign effY  = (iValid && iSof) ? '0 : yCnt;
    assign lastX = (effX == XW'(IMG_WIDTH - 1));
    assign lastY = (effY == YW'(IMG_HEIGHT - 1));
    assign col   = TX_W'(effX >> LXW);
    assign row   = TY_W'(effY >> LYW);

    assign tileFirst = (effX[LXW-1:0] == '0) && (effY[LYW-1:0] == '0);
    assign tileLast  = (&effX[LXW-1:0]) && (&effY[LYW-1:0]);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (iValid) begin
            xCnt <= lastX ? '0 : effX + XW'(1);
            if (lastX)
                yCnt <= lastY ? '0 : effY + YW'(1);
            else
                yCnt <= effY;
        end
    end

    assign curSum = entSum[col];
    assign curMin = entMin[col];
    assign curMax = entMax[col];

    // The first pixel of a tile overwrites whatever the column held, so abandoned
    // partial tiles never leak into a record.
    always_comb begin
        nxtSum = SUM_W'(iData);
        nxtMin = iData;
        nxtMax = iData;
        if (!tileFirst) begin
            nxtSum = curSum + SUM_W'(iData);
            nxtMin = (iData < curMin) ? iData : curMin;
            nxtMax = (iData > curMax) ? iData : curMax;
        end
    end

    genvar c;
    generate
        for (c = 0; c < TILES_X; c++) begin : gCol
            assign entWe[c] = iValid && (col == TX_W'(c));
            tile_stats_entry #(
                .PIX_WIDTH(PIX_WIDTH),
                .SUM_W    (SUM_W)
            ) uEntry (
                .iClk(iClk),
                .iRst(iRst),
                .iWe (entWe[c]),
                .iSum(nxtSum),
                .iMin(nxtMin),
                .iMax(nxtMax),
                .oSum(entSum[c]),
                .oMin(entMin[c]),
                .oMax(entMax[c])
            );
        end
    endgenerate

    assign vldPipe[0] = iValid && tileLast;
    assign oValid     = vldPipe[STAGES];

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            vldPipe[STAGES:1] <= '0;
            oTileX     <= '0;
            oTileY     <= '0;
            oMean      <= '0;
            oMin       <= '0;
            oMax       <= '0;
            oFrameDone <= 1'b0;
        end else begin
            vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
            oFrameDone <= vldPipe[0] && (col == TX_W'(TILES_X - 1)) && (row == TY_W'(TILES_Y - 1));
            if (vldPipe[0]) begin
                oTileX <= col;
                oTileY <= row;
                oMean  <= nxtSum[SUM_W-1:AREA_W];
                oMin   <= nxtMin;
                oMax   <= nxtMax;
            end
        end
    end

endmodule

// File: tb/tb_tile_stats_accum.sv
// Bench for tile_stats_accum on a 64x32 image with 16x16 tiles (4x2 tile grid).
// Expected records come from a frame-buffer model scanned tile by tile.

module tb_tile_stats_accum;

    localparam int W = 64, H = 32, TW = 16, TH = 16, TX = 4, TY = 2;

    logic       iClk = 1'b0, iRst = 1'b0, iValid = 1'b0, iSof = 1'b0;
    logic [7:0] iData = '0;
    logic       oValid, oFrameDone;
    logic [1:0] oTileX;
    logic [0:0] oTileY;
    logic [7:0] oMean, oMin, oMax;

    tile_stats_accum #(
        .PIX_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .TILE_WIDTH(TW), .TILE_HEIGHT(TH)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iSof(iSof), .iData(iData),
        .oValid(oValid), .oTileX(oTileX), .oTileY(oTileY), .oMean(oMean),
        .oMin(oMin), .oMax(oMax), .oFrameDone(oFrameDone)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [1:0] tx;
        logic [0:0] ty;
        logic [7:0] mean;
        logic [7:0] mn;
        logic [7:0] mx;
        logic       fd;
    } rec_t;

    rec_t       gotQ[$], expQ[$];
    time        gotT[$];
    logic [7:0] img[H][W];
    time        acc15;
    int         total = 0, bad = 0;

    always @(negedge iClk) begin
        if (oValid) begin
            gotQ.push_back({oTileX, oTileY, oMean, oMin, oMax, oFrameDone});
            gotT.push_back($time);
        end
    end

    // Reference: scan the stored frame tile by tile in emission order.
    function automatic void model_frame();
        for (int ty = 0; ty < TY; ty++)
            for (int tx = 0; tx < TX; tx++) begin
                int sum = 0, mn = 255, mx = 0;
                rec_t r;
                for (int y = ty * TH; y < (ty + 1) * TH; y++)
                    for (int x = tx * TW; x < (tx + 1) * TW; x++) begin
                        sum += img[y][x];
                        if (img[y][x] < mn) mn = img[y][x];
                        if (img[y][x] > mx) mx = img[y][x];
                    end
                r.tx = 2'(tx); r.ty = 1'(ty);
                r.mean = 8'(sum / (TW * TH)); r.mn = 8'(mn); r.mx = 8'(mx);
                r.fd = (tx == TX - 1) && (ty == TY - 1);
                expQ.push_back(r);
            end
    endfunction

    function automatic void fill(input int mode, input logic [7:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0: img[y][x] = v;
                    1: img[y][x] = 8'(x);
                    default: img[y][x] = 8'($urandom);
                endcase
    endfunction

    task automatic start();
        gotQ.delete(); gotT.delete(); expQ.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iClk);
    endtask

    // Gap cycles carry random iSof/iData, which the design must ignore.
    task automatic send(input logic [7:0] d, input bit sof, input int gapPct);
        while ($urandom_range(0, 99) < gapPct) begin
            @(negedge iClk); iValid = 1'b0; iSof = 1'($urandom); iData = 8'($urandom);
            @(posedge iClk);
        end
        @(negedge iClk); iValid = 1'b1; iSof = sof; iData = d;
        @(posedge iClk);
    endtask

    task automatic drive(input int count, input int gapPct, input bit sofFirst);
        for (int i = 0; i < count; i++) begin
            send(img[i / W][i % W], sofFirst && (i == 0), gapPct);
            if (i == 15 * W + 15) acc15 = $time;
        end
        @(negedge iClk); iValid = 1'b0; iSof = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone} !== '0) begin
            bad++; $display("FAIL reset outputs got=%h exp=0",
                {oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone});
        end
        @(negedge iClk); iRst = 1'b1;
        idle(2);
    endtask

    task automatic test_const();
        start(); fill(0, 8'h80); model_frame();
        drive(W * H, 0, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL const count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL const rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_ramp();
        start(); fill(1, 8'h00); model_frame();
        drive(W * H, 0, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL ramp count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL ramp rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
        // First record must be visible in the cycle right after pixel (15,15) is accepted.
        total++;
        if (gotT.size() == 0 || gotT[0] - acc15 != 5) begin
            bad++; $display("FAIL ramp latency got=%0t exp=5",
                gotT.size() ? gotT[0] - acc15 : 0);
        end
    endtask

    task automatic test_single();
        start(); fill(0, 8'h00); img[20][5] = 8'hFF; model_frame();
        drive(W * H, 0, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL single count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL single rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_gaps();
        start(); fill(0, 8'h80); model_frame();
        drive(W * H, 50, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL gaps count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL gaps rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill(2, 8'h00);
        drive(20 * W + 11, 10, 1'b1);
        @(posedge iClk); #2 iRst = 1'b0; #1;
        total++;
        if ({oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone} !== '0) begin
            bad++; $display("FAIL rstmid outputs got=%h exp=0",
                {oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone});
        end
        start(); idle(3);
        @(negedge iClk); iRst = 1'b1;
        fill(0, 8'h20); model_frame();
        drive(W * H, 20, 1'b0); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL rstmid count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL rstmid rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_sof_mid();
        start(); fill(2, 8'h00);
        drive(9 * W + 30, 10, 1'b1);
        fill(0, 8'h40); model_frame();
        drive(W * H, 10, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL sofmid count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL sofmid rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t l;
        start();
        fill(2, 8'h00); model_frame(); drive(W * H, 30, 1'b1);
        fill(2, 8'h00); model_frame(); drive(W * H, 30, 1'b0);
        idle(10);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL b2b count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL b2b rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
        // Data outputs keep the last record while the strobes drop.
        l = expQ[$];
        total++;
        if ({oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone} !==
            {1'b0, l.tx, l.ty, l.mean, l.mn, l.mx, 1'b0}) begin
            bad++; $display("FAIL hold got=%h exp=%h",
                {oValid, oTileX, oTileY, oMean, oMin, oMax, oFrameDone},
                {1'b0, l.tx, l.ty, l.mean, l.mn, l.mx, 1'b0});
        end
    endtask

    task automatic test_all_ff();
        start(); fill(0, 8'hFF); model_frame();
        drive(W * H, 0, 1'b1); idle(4);
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++; $display("FAIL allff count got=%0d exp=%0d", gotQ.size(), expQ.size());
        end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++; $display("FAIL allff rec%0d got=%h exp=%h", i, gotQ[i], expQ[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_single();
        test_gaps();
        test_reset_mid();
        test_sof_mid();
        test_back_to_back();
        test_all_ff();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
